// File: rtl/dpu_pkg.sv
// dpu_pkg: shared definitions for the dot-product-unit feeder.
// Holds the sequencer state encoding, default geometry and watchdog limit.
package dpu_pkg;

   localparam int DPU_DEF_WIDTH     = 16;
   localparam int DPU_DEF_NUM_UNITS = 4;
   localparam int DPU_DEF_MAX_LEN   = 8;

   // Cycles without DPU progress before the optional watchdog aborts a command
   localparam logic [15:0] DPU_TIMEOUT_LIMIT = 16'd1024;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_FEED     = 3'd2,
      ST_WAIT_RES = 3'd3,
      ST_OUTPUT   = 3'd4
   } dpu_state_e;

endpackage

// File: rtl/dpu_beat_reg.sv
// dpu_beat_reg: single-entry holding register for one operand beat.
// Accepts only while enabled and empty; the entry is dropped on pop or flush,
// and the data bus reads zero whenever nothing is held.
module dpu_beat_reg
   import dpu_pkg::*;
#(
   parameter int W = 128
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         out_pop,
   output logic [W-1:0] out_data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign in_ready = enable & ~valid_q;
   assign out_data = data_q;

   // Next-entry logic: flush wins, then load, then pop
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
         data_d  = '0;
      end else if (in_valid && in_ready) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end else if (out_pop) begin
         valid_d = 1'b0;
         data_d  = '0;
      end else begin
         valid_d = valid_q;
         data_d  = data_q;
      end
   end

   // Entry storage, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/dpu_feeder.sv
// dpu_feeder: sequences one command through a lane-parallel dot-product unit:
// latch command, pulse start, feed operand beats one at a time, capture the
// relu result and hand it out on a valid/ready port.
// Optional watchdog compiled in with `define DPU_FEEDER_TIMEOUT_EN.
module dpu_feeder
   import dpu_pkg::*;
#(
   parameter int  WIDTH     = DPU_DEF_WIDTH,
   parameter int  NUM_UNITS = DPU_DEF_NUM_UNITS,
   parameter int  MAX_LEN   = DPU_DEF_MAX_LEN,
   localparam int LEN_W     = $clog2(MAX_LEN) + 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [LEN_W-1:0]               cmd_length,
   input  logic [NUM_UNITS-1:0]           cmd_active_units,
   input  logic [NUM_UNITS-1:0][WIDTH-1:0] cmd_bias,
   input  logic                           op_valid,
   output logic                           op_ready,
   input  logic [NUM_UNITS-1:0][WIDTH-1:0] op_a,
   input  logic [NUM_UNITS-1:0][WIDTH-1:0] op_b,
   output logic                           dpu_start,
   output logic [NUM_UNITS-1:0]           dpu_active_units,
   output logic [LEN_W-1:0]               dpu_length,
   output logic [NUM_UNITS-1:0][WIDTH-1:0] dpu_a_array,
   output logic [NUM_UNITS-1:0][WIDTH-1:0] dpu_b_array,
   output logic [NUM_UNITS-1:0][WIDTH-1:0] dpu_bias_array,
   input  logic                           dpu_array_done,
   input  logic                           dpu_data_ready,
   input  logic [NUM_UNITS-1:0][WIDTH-1:0] dpu_relu_out,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [NUM_UNITS-1:0][WIDTH-1:0] res_data,
   output logic                           cmd_err,
   output logic                           busy
);

   localparam int LANE_W = NUM_UNITS * WIDTH;

   dpu_state_e                     state_q, state_d;
   logic [LEN_W-1:0]               len_q, len_d, cnt_q, cnt_d;
   logic [NUM_UNITS-1:0]           act_q, act_d;
   logic [NUM_UNITS-1:0][WIDTH-1:0] bias_q, bias_d, res_q, res_d;
   logic                           cmd_ready_q, cmd_ready_d;
   logic                           cmd_err_q, cmd_err_d;
   logic                           start_q, start_d;
   logic                           res_valid_q, res_valid_d;
   logic                           busy_q, busy_d;

   logic [NUM_UNITS-1:0][WIDTH-1:0] a_mask_s, b_mask_s, relu_mask_s;
   logic                           cmd_bad_s, timeout_s, feeding_s;
   logic [2*LANE_W-1:0]            beat_out_s;

   assign cmd_ready        = cmd_ready_q;
   assign cmd_err          = cmd_err_q;
   assign dpu_start        = start_q;
   assign res_valid        = res_valid_q;
   assign busy             = busy_q;
   assign dpu_length       = len_q;
   assign dpu_active_units = act_q;
   assign dpu_bias_array   = bias_q;
   assign res_data         = res_q;
   assign dpu_a_array      = beat_out_s[2*LANE_W-1:LANE_W];
   assign dpu_b_array      = beat_out_s[LANE_W-1:0];
   assign feeding_s        = (state_q == ST_FEED);

   // Zero the lanes of the latched command that are switched off
   always_comb begin
      a_mask_s    = '0;
      b_mask_s    = '0;
      relu_mask_s = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (act_q[i]) begin
            a_mask_s[i]    = op_a[i];
            b_mask_s[i]    = op_b[i];
            relu_mask_s[i] = dpu_relu_out[i];
         end else begin
            a_mask_s[i]    = '0;
            b_mask_s[i]    = '0;
            relu_mask_s[i] = '0;
         end
      end
   end

   dpu_beat_reg #(.W(2*LANE_W)) u_beat (
      .clk      (clk),
      .reset    (reset),
      .enable   (feeding_s),
      .flush    (~feeding_s | timeout_s),
      .in_valid (op_valid),
      .in_ready (op_ready),
      .in_data  ({a_mask_s, b_mask_s}),
      .out_pop  (feeding_s & dpu_array_done),
      .out_data (beat_out_s)
   );

`ifdef DPU_FEEDER_TIMEOUT_EN
   logic [15:0] wd_q, wd_d;

   // Watchdog: count stalled cycles while waiting on the DPU
   always_comb begin
      wd_d      = '0;
      timeout_s = 1'b0;
      if ((feeding_s && !dpu_array_done) ||
          ((state_q == ST_WAIT_RES) && !dpu_data_ready)) begin
         wd_d = wd_q + 16'd1;
         if (wd_d == DPU_TIMEOUT_LIMIT) begin
            timeout_s = 1'b1;
            wd_d      = '0;
         end else begin
            timeout_s = 1'b0;
         end
      end else begin
         wd_d = '0;
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Sequencer next state, command latching and registered output decode
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      act_d     = act_q;
      bias_d    = bias_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      cmd_err_d = 1'b0;
      cmd_bad_s = (cmd_length == '0) || (cmd_length > LEN_W'(MAX_LEN)) ||
                  (cmd_active_units == '0);
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               if (cmd_bad_s) begin
                  cmd_err_d = 1'b1;
               end else begin
                  len_d   = cmd_length;
                  act_d   = cmd_active_units;
                  bias_d  = cmd_bias;
                  cnt_d   = '0;
                  state_d = ST_START;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            state_d = ST_FEED;
         end
         ST_FEED: begin
            if (dpu_array_done) begin
               if ((cnt_q + LEN_W'(1)) == len_q) begin
                  cnt_d   = '0;
                  state_d = ST_WAIT_RES;
               end else begin
                  cnt_d = cnt_q + LEN_W'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_WAIT_RES: begin
            if (dpu_data_ready) begin
               res_d   = relu_mask_s;
               state_d = ST_OUTPUT;
            end else begin
               state_d = ST_WAIT_RES;
            end
         end
         ST_OUTPUT: begin
            if (res_ready) begin
               len_d   = '0;
               act_d   = '0;
               bias_d  = '0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUTPUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (timeout_s) begin
         cmd_err_d = 1'b1;
         len_d     = '0;
         act_d     = '0;
         bias_d    = '0;
         cnt_d     = '0;
         state_d   = ST_IDLE;
      end else begin
         cmd_err_d = cmd_err_d;
      end
      cmd_ready_d = (state_d == ST_IDLE);
      start_d     = (state_d == ST_START);
      res_valid_d = (state_d == ST_OUTPUT);
      busy_d      = (state_d != ST_IDLE);
   end

   // State and output registers, all cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         act_q       <= '0;
         bias_q      <= '0;
         cnt_q       <= '0;
         res_q       <= '0;
         cmd_ready_q <= 1'b0;
         cmd_err_q   <= 1'b0;
         start_q     <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         act_q       <= act_d;
         bias_q      <= bias_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         cmd_ready_q <= cmd_ready_d;
         cmd_err_q   <= cmd_err_d;
         start_q     <= start_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_dpu_feeder.sv
// tb_dpu_feeder: directed, table-driven bench for dpu_feeder with a small
// Q8.8 dot-product-unit model on the drive side.
// Define DPU_FEEDER_TIMEOUT_EN to also exercise the watchdog.
module tb_dpu_feeder;

   localparam int WIDTH = 16;
   localparam int NU    = 4;
   localparam int ML    = 8;
   localparam int LW    = 4;

   typedef logic [NU-1:0][WIDTH-1:0] lanes_t;

   typedef struct {
      logic [LW-1:0] len;
      logic [NU-1:0] act;
      lanes_t        a;
      lanes_t        b;
      lanes_t        bias;
      lanes_t        exp_res;
      bit            exp_err;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready;
   logic [LW-1:0] cmd_length;
   logic [NU-1:0] cmd_active_units;
   lanes_t        cmd_bias;
   logic          op_valid, op_ready;
   lanes_t        op_a, op_b;
   logic          dpu_start;
   logic [NU-1:0] dpu_active_units;
   logic [LW-1:0] dpu_length;
   lanes_t        dpu_a_array, dpu_b_array, dpu_bias_array;
   logic          dpu_array_done, dpu_data_ready;
   lanes_t        dpu_relu_out;
   logic          res_valid, res_ready;
   lanes_t        res_data;
   logic          cmd_err, busy;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs[7];

   // monitor counters, written only by the monitor process
   int n_start = 0, n_beat = 0, n_viol = 0, n_resv = 0;

   // DPU model state
   logic signed [31:0] acc [NU];
   int  m_len, m_cnt;
   logic m_pending, m_fire;
   bit  suppress_ready = 1'b0;

   dpu_feeder #(.WIDTH(WIDTH), .NUM_UNITS(NU), .MAX_LEN(ML)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_length(cmd_length),
      .cmd_active_units(cmd_active_units), .cmd_bias(cmd_bias),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .dpu_start(dpu_start), .dpu_active_units(dpu_active_units),
      .dpu_length(dpu_length), .dpu_a_array(dpu_a_array),
      .dpu_b_array(dpu_b_array), .dpu_bias_array(dpu_bias_array),
      .dpu_array_done(dpu_array_done), .dpu_data_ready(dpu_data_ready),
      .dpu_relu_out(dpu_relu_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .cmd_err(cmd_err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic lanes_t mk(input logic [15:0] l0, l1, l2, l3);
      lanes_t r;
      r[0] = l0; r[1] = l1; r[2] = l2; r[3] = l3;
      return r;
   endfunction

   function automatic logic signed [31:0] prod_f(input logic [15:0] a, b);
      logic signed [31:0] sa, sb;
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return (sa * sb) >>> 8;
   endfunction

   function automatic logic [15:0] relu_f(input logic signed [31:0] s, input logic [15:0] bias);
      logic signed [31:0] t;
      t = s + {{16{bias[15]}}, bias};
      if (t < 0) return 16'h0000;
      return t[15:0];
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // DPU model: one cycle after a beat is held, consume it and pulse done;
   // the cycle after the last done, return relu(acc + bias)
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         dpu_array_done <= 1'b0;
         dpu_data_ready <= 1'b0;
         dpu_relu_out   <= '0;
         m_pending      <= 1'b0;
         m_fire         <= 1'b0;
         m_cnt          <= 0;
         m_len          <= 0;
         for (int i = 0; i < NU; i++) acc[i] <= 32'sd0;
      end else begin
         dpu_array_done <= 1'b0;
         dpu_data_ready <= 1'b0;
         if (dpu_start) begin
            m_cnt <= 0;
            m_len <= int'(dpu_length);
            for (int i = 0; i < NU; i++) acc[i] <= 32'sd0;
         end
         if (op_valid && op_ready) m_pending <= 1'b1;
         if (m_pending) begin
            m_pending <= 1'b0;
            for (int i = 0; i < NU; i++)
               acc[i] <= acc[i] + prod_f(dpu_a_array[i], dpu_b_array[i]);
            dpu_array_done <= 1'b1;
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_len) m_fire <= 1'b1;
         end
         if (m_fire) begin
            m_fire <= 1'b0;
            if (!suppress_ready) begin
               dpu_data_ready <= 1'b1;
               for (int i = 0; i < NU; i++)
                  dpu_relu_out[i] <= relu_f(acc[i], dpu_bias_array[i]);
            end
         end
      end
   end

   // Monitor: start pulses, accepted beats, live data on inactive lanes, res_valid cycles
   always @(posedge clk) begin
      if (reset) begin
         if (dpu_start) n_start <= n_start + 1;
         if (op_valid && op_ready) n_beat <= n_beat + 1;
         if (res_valid) n_resv <= n_resv + 1;
         for (int i = 0; i < NU; i++)
            if (!dpu_active_units[i] && (dpu_a_array[i] != '0 || dpu_b_array[i] != '0))
               n_viol <= n_viol + 1;
      end
   end

   task automatic wait_cmd_ready();
      bit got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
         if (cmd_ready) got = 1'b1;
         else @(negedge clk);
      end
      check("cmd_ready wait", got, 1'b1);
   endtask

   task automatic send_cmd(input logic [LW-1:0] len, input logic [NU-1:0] act, input lanes_t bias);
      wait_cmd_ready();
      cmd_valid = 1'b1; cmd_length = len; cmd_active_units = act; cmd_bias = bias;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic feed_beat(input lanes_t a, input lanes_t b);
      bit got = 1'b0;
      op_a = a; op_b = b; op_valid = 1'b1;
      for (int t = 0; t < 40 && !got; t++) begin
         if (op_ready) got = 1'b1;
         @(negedge clk);
      end
      op_valid = 1'b0;
      check("op_ready wait", got, 1'b1);
   endtask

   task automatic run_vec(input int idx, input int hold);
      int s0, b0, v0;
      bit got, stable;
      s0 = n_start; b0 = n_beat; v0 = n_viol;
      send_cmd(vecs[idx].len, vecs[idx].act, vecs[idx].bias);
      if (vecs[idx].exp_err) begin
         check($sformatf("v%0d cmd_err pulse", idx), cmd_err, 1'b1);
         check($sformatf("v%0d busy on err", idx), busy, 1'b0);
         check($sformatf("v%0d cmd_ready on err", idx), cmd_ready, 1'b1);
         @(negedge clk);
         check($sformatf("v%0d cmd_err low", idx), cmd_err, 1'b0);
         check($sformatf("v%0d no start", idx), 64'(n_start - s0), 64'd0);
      end else begin
         check($sformatf("v%0d busy", idx), busy, 1'b1);
         for (int k = 0; k < int'(vecs[idx].len); k++) feed_beat(vecs[idx].a, vecs[idx].b);
         got = 1'b0;
         for (int t = 0; t < 100 && !got; t++) begin
            if (res_valid) got = 1'b1;
            else @(negedge clk);
         end
         check($sformatf("v%0d res_valid wait", idx), got, 1'b1);
         check($sformatf("v%0d res_data", idx), res_data, vecs[idx].exp_res);
         check($sformatf("v%0d start count", idx), 64'(n_start - s0), 64'd1);
         check($sformatf("v%0d beat count", idx), 64'(n_beat - b0), 64'(vecs[idx].len));
         check($sformatf("v%0d inactive lanes", idx), 64'(n_viol - v0), 64'd0);
         if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               if (!res_valid || res_data !== vecs[idx].exp_res || cmd_ready) stable = 1'b0;
            end
            check($sformatf("v%0d output hold", idx), stable, 1'b1);
         end
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
         check($sformatf("v%0d res_valid drop", idx), res_valid, 1'b0);
         check($sformatf("v%0d cmd_ready after", idx), cmd_ready, 1'b1);
         check($sformatf("v%0d busy after", idx), busy, 1'b0);
      end
   endtask

   initial begin
      vecs[0] = '{len: 4'd3, act: 4'b1111,
                  a: mk(16'h0100, 16'h0100, 16'hFF00, 16'h0000),
                  b: mk(16'h0200, 16'h0100, 16'h0100, 16'h0000),
                  bias: mk(16'h0000, 16'h0000, 16'h0000, 16'h0000),
                  exp_res: mk(16'h0600, 16'h0300, 16'h0000, 16'h0000), exp_err: 1'b0};
      vecs[1] = '{len: 4'd0, act: 4'b1111, a: '0, b: '0, bias: '0, exp_res: '0, exp_err: 1'b1};
      vecs[2] = '{len: 4'd2, act: 4'b0101,
                  a: mk(16'h0100, 16'h0200, 16'h0300, 16'h0400),
                  b: mk(16'h0100, 16'h0100, 16'h0100, 16'h0100),
                  bias: mk(16'h0000, 16'h0100, 16'h0000, 16'h0100),
                  exp_res: mk(16'h0200, 16'h0000, 16'h0600, 16'h0000), exp_err: 1'b0};
      vecs[3] = '{len: 4'd9, act: 4'b1111, a: '0, b: '0, bias: '0, exp_res: '0, exp_err: 1'b1};
      vecs[4] = '{len: 4'd2, act: 4'b0000, a: '0, b: '0, bias: '0, exp_res: '0, exp_err: 1'b1};
      vecs[5] = '{len: 4'd1, act: 4'b1111,
                  a: mk(16'h0100, 16'h0200, 16'hFF00, 16'h0100),
                  b: mk(16'h0100, 16'h0100, 16'h0100, 16'h0080),
                  bias: mk(16'h0000, 16'hFF00, 16'h0300, 16'h0100),
                  exp_res: mk(16'h0100, 16'h0100, 16'h0200, 16'h0180), exp_err: 1'b0};
      vecs[6] = '{len: 4'd8, act: 4'b0001,
                  a: mk(16'h0100, 16'h0500, 16'h0500, 16'h0500),
                  b: mk(16'h0020, 16'h0100, 16'h0100, 16'h0100),
                  bias: mk(16'h0000, 16'h0100, 16'h0100, 16'h0100),
                  exp_res: mk(16'h0100, 16'h0000, 16'h0000, 16'h0000), exp_err: 1'b0};

      reset = 1'b0; cmd_valid = 1'b0; cmd_length = '0; cmd_active_units = '0;
      cmd_bias = '0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;

      // reset state
      #12;
      check("rst cmd_ready", cmd_ready, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst res_valid", res_valid, 1'b0);
      check("rst dpu_start", dpu_start, 1'b0);
      check("rst op_ready", op_ready, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("cmd_ready after reset", cmd_ready, 1'b1);

      // table
      for (int i = 0; i < 7; i++) run_vec(i, 0);

      // result held while res_ready stays low
      run_vec(0, 10);

      // reset in the middle of the second beat
      begin
         int r0;
         send_cmd(4'd3, 4'b1111, mk(16'h0000, 16'h0000, 16'h0000, 16'h0000));
         feed_beat(mk(16'h0100, 16'h0100, 16'h0100, 16'h0100), mk(16'h0100, 16'h0100, 16'h0100, 16'h0100));
         feed_beat(mk(16'h0200, 16'h0200, 16'h0200, 16'h0200), mk(16'h0100, 16'h0100, 16'h0100, 16'h0100));
         check("beat2 held", dpu_a_array, mk(16'h0200, 16'h0200, 16'h0200, 16'h0200));
         #2 reset = 1'b0;
         #1;
         check("midrst dpu_a", dpu_a_array, 64'd0);
         check("midrst busy", busy, 1'b0);
         check("midrst cmd_ready", cmd_ready, 1'b0);
         check("midrst dpu_length", dpu_length, 4'd0);
         @(negedge clk);
         reset = 1'b1;
         r0 = n_resv;
         repeat (20) @(negedge clk);
         check("midrst no res_valid", 64'(n_resv - r0), 64'd0);
         check("midrst idle", busy, 1'b0);
         check("midrst cmd_ready", cmd_ready, 1'b1);
      end

`ifdef DPU_FEEDER_TIMEOUT_EN
      // watchdog: DPU never returns a result
      begin
         int cyc;
         bit got;
         suppress_ready = 1'b1;
         send_cmd(4'd1, 4'b1111, mk(16'h0000, 16'h0000, 16'h0000, 16'h0000));
         feed_beat(mk(16'h0100, 16'h0100, 16'h0100, 16'h0100), mk(16'h0100, 16'h0100, 16'h0100, 16'h0100));
         got = 1'b0; cyc = 0;
         for (int t = 0; t < 1200 && !got; t++) begin
            if (cmd_err) got = 1'b1;
            else begin
               @(negedge clk);
               cyc++;
            end
         end
         check("wd cmd_err", got, 1'b1);
         check("wd delay in range", (cyc >= 1020 && cyc <= 1030), 1'b1);
         check("wd busy", busy, 1'b0);
         check("wd cmd_ready", cmd_ready, 1'b1);
         suppress_ready = 1'b0;
      end
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
